// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencing controller.
//   - state_e      : controller states (IDLE, LOAD, RUN, DONE)
//   - OP_BZ/OP_JMP : opcode encodings held in the top three instruction bits
//   - *_DEF        : default widths for instruction, PC and branch offset
//   - is_halt()    : HALT is a JMP whose offset is zero (jump-to-self)
package fetch_pkg;

    localparam int INSTR_W_DEF = 9;
    localparam int PC_W_DEF    = 8;
    localparam int OFF_W_DEF   = 6;

    localparam logic [2:0] OP_BZ  = 3'b111;
    localparam logic [2:0] OP_JMP = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Takes the opcode and a "offset field is zero" flag so it works for
    // any offset width.
    function automatic logic is_halt(input logic [2:0] op, input logic off_is_zero);
        return (op == OP_JMP) && off_is_zero;
    endfunction

endpackage

// File: rtl/branch_decide.sv
// branch_decide: combinational instruction decode for the fetch controller.
// Ports:
//   instr_i     in  INSTR_W  instruction at the current PC
//   zero_flag_i in  1        registered architectural zero flag
//   branch_o    out 1        taken branch (JMP, or BZ with flag set); never on HALT
//   offset_o    out OFF_W    instr_i[OFF_W-1:0], passed through unconditionally
//   halt_o      out 1        instruction is HALT
module branch_decide
    import fetch_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OFF_W   = OFF_W_DEF
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               zero_flag_i,
    output logic               branch_o,
    output logic [OFF_W-1:0]   offset_o,
    output logic               halt_o
);

    logic [2:0] op;

    assign op       = instr_i[INSTR_W-1 -: 3];
    assign offset_o = instr_i[OFF_W-1:0];
    assign halt_o   = is_halt(op, offset_o == '0);
    // HALT is encoded as a JMP but must not request a branch.
    assign branch_o = !halt_o && ((op == OP_JMP) || ((op == OP_BZ) && zero_flag_i));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller driving the fetch unit's PC controls.
// Sequence: IDLE --Go--> LOAD (Start pulse) --> RUN (branch decisions,
// watchdog) --HALT/timeout--> DONE (held until Go drops) --> IDLE.
// Handshake: Go is a level; it is accepted in IDLE, ignored in LOAD/RUN,
// and in DONE it must be seen low before the controller returns to IDLE.
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   Go, Go_Addr           run request and program start address
//   Instr                 instruction at the current PC
//   Alu_Zero, Zero_We     zero-flag write data and enable (any state)
//   Start, Start_Addr     load PC from Start_Addr (one LOAD cycle)
//   Branch, Offset        PC <= PC + Offset when Branch (RUN only)
//   Done, Timeout         program finished; finish caused by watchdog
//   Zero_Flag             current zero flag
// Optional (macro FETCH_CTRL_PERF_EN):
//   Cycle_Count, Branch_Count  RUN cycles / taken branches of last program,
//                              cleared in LOAD, saturating at 16'hFFFF
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int MAX_CYCLES = 4096
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Go,
    input  logic [PC_W-1:0]    Go_Addr,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               Alu_Zero,
    input  logic               Zero_We,
    output logic               Start,
    output logic [PC_W-1:0]    Start_Addr,
    output logic               Branch,
    output logic [OFF_W-1:0]   Offset,
    output logic               Done,
    output logic               Timeout,
`ifdef FETCH_CTRL_PERF_EN
    output logic [15:0]        Cycle_Count,
    output logic [15:0]        Branch_Count,
`endif
    output logic               Zero_Flag
);

    localparam int               CNT_W    = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_e            state_q;
    logic              start_q;
    logic [PC_W-1:0]   start_addr_q;
    logic              done_q;
    logic              timeout_q;
    logic              zero_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              dec_branch;
    logic              dec_halt;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0]       cyc_cnt_q;
    logic [15:0]       br_cnt_q;
`endif

    branch_decide #(
        .INSTR_W (INSTR_W),
        .OFF_W   (OFF_W)
    ) u_branch_decide (
        .instr_i     (Instr),
        .zero_flag_i (zero_q),
        .branch_o    (dec_branch),
        .offset_o    (Offset),
        .halt_o      (dec_halt)
    );

    // Branch reflects the current instruction and the old flag; only live in RUN.
    assign Branch     = (state_q == RUN) && dec_branch;
    assign Start      = start_q;
    assign Start_Addr = start_addr_q;
    assign Done       = done_q;
    assign Timeout    = timeout_q;
    assign Zero_Flag  = zero_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            start_addr_q <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            zero_q       <= 1'b0;
            cnt_q        <= '0;
`ifdef FETCH_CTRL_PERF_EN
            cyc_cnt_q    <= '0;
            br_cnt_q     <= '0;
`endif
        end else begin
            if (Zero_We) begin
                zero_q <= Alu_Zero;
            end

            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    if (Go) begin
                        state_q      <= LOAD;
                        start_addr_q <= Go_Addr;
                        start_q      <= 1'b1;
                    end
                end

                LOAD: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= RUN;
`ifdef FETCH_CTRL_PERF_EN
                    cyc_cnt_q <= '0;
                    br_cnt_q  <= '0;
`endif
                end

                RUN: begin
`ifdef FETCH_CTRL_PERF_EN
                    if (cyc_cnt_q != 16'hFFFF) cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    if (dec_branch && (br_cnt_q != 16'hFFFF)) br_cnt_q <= br_cnt_q + 16'd1;
`endif
                    // HALT has priority over the watchdog on the same cycle.
                    if (dec_halt) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        // Only advanced while staying in RUN, so it never wraps.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (!Go) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    assign Cycle_Count  = cyc_cnt_q;
    assign Branch_Count = br_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized self-checking bench for fetch_ctrl with a
// program-level reference model (flag, branch rule, halt/watchdog outcome).
module tb_fetch_ctrl;

    localparam int MAXC = 16;

    logic       CLK;
    logic       Reset;
    logic       Go;
    logic [7:0] Go_Addr;
    logic [8:0] Instr;
    logic       Alu_Zero;
    logic       Zero_We;
    logic       Start;
    logic [7:0] Start_Addr;
    logic       Branch;
    logic [5:0] Offset;
    logic       Done;
    logic       Timeout;
    logic       Zero_Flag;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] Cycle_Count;
    logic [15:0] Branch_Count;
`endif

    fetch_ctrl #(
        .INSTR_W    (9),
        .PC_W       (8),
        .OFF_W      (6),
        .MAX_CYCLES (MAXC)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Go         (Go),
        .Go_Addr    (Go_Addr),
        .Instr      (Instr),
        .Alu_Zero   (Alu_Zero),
        .Zero_We    (Zero_We),
        .Start      (Start),
        .Start_Addr (Start_Addr),
        .Branch     (Branch),
        .Offset     (Offset),
        .Done       (Done),
        .Timeout    (Timeout),
`ifdef FETCH_CTRL_PERF_EN
        .Cycle_Count  (Cycle_Count),
        .Branch_Count (Branch_Count),
`endif
        .Zero_Flag  (Zero_Flag)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- scoreboard state ----------------
    int n_checks   = 0;
    int n_failures = 0;

    logic [6:0] exp_q[$];     // {branch, offset} expected for each RUN cycle
    logic       m_flag;       // reference zero flag
    int         m_cycles;     // RUN cycles of the current program
    int         m_taken;      // taken branches of the current program

    logic [8:0] dir_instr[$]; // optional directed RUN-cycle stimulus
    logic       dir_we[$];
    logic       dir_az[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply the zero-flag rule at the edge, return at the next negedge.
    task automatic tick();
        @(posedge CLK);
        if (Reset) m_flag = 1'b0;
        else if (Zero_We) m_flag = Alu_Zero;
        @(negedge CLK);
    endtask

    function automatic logic [8:0] rand_non_halt();
        logic [2:0] op;
        logic [5:0] off;
        op  = 3'($urandom_range(0, 7));
        off = 6'($urandom);
        if (op == 3'b110 && off == 6'd0) off = 6'd1;
        return {op, off};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_start"},   Start,     0);
        check_eq({tag, "_branch"},  Branch,    0);
        check_eq({tag, "_done"},    Done,      0);
        check_eq({tag, "_timeout"}, Timeout,   0);
    endtask

    // Runs one program. halt_at: RUN cycle carrying HALT (0 = never).
    // reset_at: RUN cycle in which Reset is asserted (0 = never).
    task automatic run_program(input logic [7:0] addr, input int halt_at, input int reset_at);
        logic [8:0] ins;
        logic       is_halt_i;
        logic       exp_br;
        logic [6:0] exp_pair;
        logic       exp_to;
        bit         ended;
        ended  = 0;
        exp_to = 0;

        // IDLE cycle: request accepted
        Go = 1'b1; Go_Addr = addr; Instr = 9'($urandom); Zero_We = 1'b0;
        #1;
        check_idle_outputs("idle");
        check_eq("idle_zero_flag", Zero_Flag, m_flag);
        tick();

        // LOAD cycle: Go and Go_Addr changes must be ignored
        Go = 1'($urandom); Go_Addr = 8'($urandom); Instr = 9'($urandom);
        #1;
        check_eq("load_start",      Start,      1);
        check_eq("load_start_addr", Start_Addr, addr);
        check_eq("load_branch",     Branch,     0);
        check_eq("load_done",       Done,       0);
        tick();

        m_cycles = 0;
        m_taken  = 0;
        for (int k = 1; k <= MAXC && !ended; k++) begin
            if (dir_instr.size() > 0) begin
                ins      = dir_instr.pop_front();
                Zero_We  = dir_we.pop_front();
                Alu_Zero = dir_az.pop_front();
            end else begin
                ins      = (k == halt_at) ? 9'b110_000000 : rand_non_halt();
                Zero_We  = 1'($urandom_range(0, 1));
                Alu_Zero = 1'($urandom_range(0, 1));
            end
            Instr = ins;
            Go    = 1'($urandom);

            if (k == reset_at) begin
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
                Go    = 1'b0;
                #1;
                check_idle_outputs("rst_mid");
                check_eq("rst_mid_zero_flag",  Zero_Flag,  0);
                check_eq("rst_mid_start_addr", Start_Addr, 0);
`ifdef FETCH_CTRL_PERF_EN
                check_eq("rst_mid_cycle_count",  Cycle_Count,  0);
                check_eq("rst_mid_branch_count", Branch_Count, 0);
`endif
                tick();
                return;
            end

            // reference: JMP (not HALT) always branches, BZ uses the pre-edge flag
            is_halt_i = (ins[8:6] == 3'b110) && (ins[5:0] == 6'd0);
            exp_br    = !is_halt_i && ((ins[8:6] == 3'b110) || (ins[8:6] == 3'b111 && m_flag));
            exp_q.push_back({exp_br, ins[5:0]});
            #1;
            exp_pair = exp_q.pop_front();
            check_eq("run_branch",    Branch,    exp_pair[6]);
            check_eq("run_offset",    Offset,    exp_pair[5:0]);
            check_eq("run_zero_flag", Zero_Flag, m_flag);
            check_eq("run_done",      Done,      0);
            check_eq("run_start",     Start,     0);
            tick();
            m_cycles++;
            if (exp_br) m_taken++;
            if (is_halt_i) ended = 1;
            else if (k == MAXC) begin ended = 1; exp_to = 1; end
        end

        // DONE held while Go stays high
        Zero_We = 1'b0;
        Go = 1'b1;
        for (int j = 0; j < 3; j++) begin
            Instr = 9'($urandom);
            #1;
            check_eq("done_done",    Done,      1);
            check_eq("done_timeout", Timeout,   exp_to);
            check_eq("done_branch",  Branch,    0);
            check_eq("done_start",   Start,     0);
            check_eq("done_zero",    Zero_Flag, m_flag);
`ifdef FETCH_CTRL_PERF_EN
            check_eq("perf_cycles",   Cycle_Count,  m_cycles);
            check_eq("perf_branches", Branch_Count, m_taken);
`endif
            tick();
        end
        Go = 1'b0;
        #1;
        check_eq("done_release_hold", Done, 1);
        tick();
        #1;
        check_idle_outputs("after_done");
`ifdef FETCH_CTRL_PERF_EN
        check_eq("perf_hold_cycles", Cycle_Count, m_cycles);
`endif
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Reset = 1'b1; Go = 1'b0; Go_Addr = 8'h00; Instr = 9'h000;
        Alu_Zero = 1'b0; Zero_We = 1'b0; m_flag = 1'b0;
        @(negedge CLK);
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        check_idle_outputs("reset");
        check_eq("reset_zero_flag",  Zero_Flag,  0);
        check_eq("reset_start_addr", Start_Addr, 0);
        tick();

        // Directed: flag set then BZ taken, flag cleared then BZ not taken,
        // BZ concurrent with a flag write uses the old flag, then HALT.
        dir_instr = '{9'b000_000000, 9'b111_000101, 9'b000_000000,
                      9'b111_000101, 9'b111_000101, 9'b000_000000};
        dir_we    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        dir_az    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_program(8'h20, 7, 0);

        // Watchdog with no HALT, then HALT exactly on the limit cycle.
        run_program(8'($urandom), 0, 0);
        run_program(8'($urandom), MAXC, 0);

        // Randomized programs.
        for (int p = 0; p < 12; p++) begin
            run_program(8'($urandom), $urandom_range(0, MAXC), 0);
        end

        // Reset mid-RUN with the flag forced high first.
        dir_instr = '{9'b000_000000, 9'b110_000011};
        dir_we    = '{1'b1, 1'b0};
        dir_az    = '{1'b1, 1'b0};
        run_program(8'h5A, 0, 4);

        // Controller must be usable again after the mid-RUN reset.
        run_program(8'h33, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

    // Absolute time bound in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        n_failures++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $fatal(1);
    end

endmodule
